// File: rtl/sd_rx_pkg.sv
// SD DAT receive shared definitions: FSM state codes, status codes,
// CRC16 polynomial and a word-packing helper.
package sd_rx_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_CRC        = 3'd3;
    localparam logic [2:0] ST_END        = 3'd4;
    localparam logic [2:0] ST_WAIT_DMA   = 3'd5;

    localparam logic [1:0] STAT_OK      = 2'd0;
    localparam logic [1:0] STAT_TIMEOUT = 2'd1;
    localparam logic [1:0] STAT_CRC_ERR = 2'd2;
    localparam logic [1:0] STAT_ABORT   = 2'd3;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // Nibble idx within a word: byte idx[2:1], high nibble when idx[0]==0.
    function automatic logic [31:0] put_nibble(
        input logic [31:0] w,
        input logic [2:0]  idx,
        input logic [3:0]  nib
    );
        logic [4:0]  pos;
        logic [31:0] r;
        pos = {idx[2:1], ~idx[0], 2'b00};
        r = w;
        r[pos +: 4] = nib;
        return r;
    endfunction

endpackage

// File: rtl/sd_data_rx_if.sv
// Rx stream between the SD DAT receiver (master) and the DMA controller.
// Carries packed words, block-start markers, pending and DMA completion.
interface sd_data_rx_if;
    logic [31:0] rx_data_in;
    logic        rx_data_strobe;
    logic        rx_block_starting;
    logic        rx_block_is_first;
    logic        rx_pending;
    logic        rx_dma_done;

    modport master (
        output rx_data_in, rx_data_strobe, rx_block_starting,
        output rx_block_is_first, rx_pending,
        input  rx_dma_done
    );

    modport slave (
        input  rx_data_in, rx_data_strobe, rx_block_starting,
        input  rx_block_is_first, rx_pending,
        output rx_dma_done
    );
endinterface

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), init 0, MSB first.
// Ports: clk, reset, clear, enable, din -> crc.
module sd_crc16_serial
    import sd_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= 16'h0000;
        end else if (enable) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_data_rx.sv
// SD 4-bit DAT multi-block receiver: deserialise, pack LE words, check
// per-line CRC16/end bit. Ports: clk, reset, sd_clk_en, sd_dat_in, start,
// abort, block_len, block_count, timeout, rx (stream), busy, done,
// status, blocks_done.
module sd_data_rx
    import sd_rx_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sd_clk_en,
    input  logic [3:0]           sd_dat_in,
    input  logic                 start,
    input  logic                 abort,
    input  logic [11:0]          block_len,
    input  logic [15:0]          block_count,
    input  logic [TIMEOUT_W-1:0] timeout,
    sd_data_rx_if.master         rx,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [15:0]          blocks_done
);

    logic [2:0]           state;
    logic [11:0]          len_q;
    logic [15:0]          cnt_q;
    logic [12:0]          nib_cnt;
    logic [3:0]           crc_cnt;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [TIMEOUT_W-1:0] tmo_nx;
    logic [31:0]          word_q;
    logic [31:0]          word_nx;
    logic [15:0]          rx_crc [4];
    logic [15:0]          calc_crc [4];
    logic                 crc_clear;
    logic                 crc_en;
    logic                 crc_ok;
    logic                 last_nib;
    logic                 abortable;

    assign busy      = (state != ST_IDLE);
    assign crc_clear = (state == ST_WAIT_START) && sd_clk_en
                       && (sd_dat_in == 4'h0);
    assign crc_en    = (state == ST_DATA) && sd_clk_en;
    assign last_nib  = (nib_cnt == ({len_q, 1'b0} - 13'd1));
    assign word_nx   = put_nibble(word_q, nib_cnt[2:0], sd_dat_in);
    assign tmo_nx    = tmo_cnt + 1'b1;
    assign abortable = (state == ST_WAIT_START) || (state == ST_DATA)
                       || (state == ST_CRC) || (state == ST_END);

    for (genvar l = 0; l < 4; l++) begin : g_crc
        sd_crc16_serial u_crc (
            .clk    (clk),
            .reset  (reset),
            .clear  (crc_clear),
            .enable (crc_en),
            .din    (sd_dat_in[l]),
            .crc    (calc_crc[l])
        );
    end

    always_comb begin
        crc_ok = 1'b1;
        for (int l = 0; l < 4; l++) begin
            if (calc_crc[l] != rx_crc[l]) crc_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            len_q                <= '0;
            cnt_q                <= '0;
            nib_cnt              <= '0;
            crc_cnt              <= '0;
            tmo_cnt              <= '0;
            word_q               <= '0;
            for (int l = 0; l < 4; l++) rx_crc[l] <= '0;
            done                 <= 1'b0;
            status               <= STAT_OK;
            blocks_done          <= '0;
            rx.rx_data_in        <= '0;
            rx.rx_data_strobe    <= 1'b0;
            rx.rx_block_starting <= 1'b0;
            rx.rx_block_is_first <= 1'b0;
            rx.rx_pending        <= 1'b0;
        end else begin
            done                 <= 1'b0;
            rx.rx_data_strobe    <= 1'b0;
            rx.rx_block_starting <= 1'b0;
            rx.rx_block_is_first <= 1'b0;
            if (abort && abortable) begin
                status <= STAT_ABORT;
                state  <= ST_WAIT_DMA;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            len_q         <= block_len;
                            cnt_q         <= (block_count == 16'd0)
                                             ? 16'd1 : block_count;
                            blocks_done   <= '0;
                            status        <= STAT_OK;
                            tmo_cnt       <= '0;
                            rx.rx_pending <= 1'b1;
                            state         <= ST_WAIT_START;
                        end
                    end
                    ST_WAIT_START: begin
                        if (sd_clk_en) begin
                            if (sd_dat_in == 4'h0) begin
                                rx.rx_block_starting <= 1'b1;
                                rx.rx_block_is_first <= (blocks_done == 16'd0);
                                nib_cnt              <= '0;
                                crc_cnt              <= '0;
                                state                <= ST_DATA;
                            end else begin
                                tmo_cnt <= tmo_nx;
                                if ((timeout != '0) && (tmo_nx == timeout)) begin
                                    status <= STAT_TIMEOUT;
                                    state  <= ST_WAIT_DMA;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sd_clk_en) begin
                            word_q  <= word_nx;
                            nib_cnt <= nib_cnt + 13'd1;
                            if (nib_cnt[2:0] == 3'd7) begin
                                rx.rx_data_in     <= word_nx;
                                rx.rx_data_strobe <= 1'b1;
                            end
                            if (last_nib) state <= ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (sd_clk_en) begin
                            for (int l = 0; l < 4; l++) begin
                                rx_crc[l] <= {rx_crc[l][14:0], sd_dat_in[l]};
                            end
                            crc_cnt <= crc_cnt + 4'd1;
                            if (crc_cnt == 4'd15) state <= ST_END;
                        end
                    end
                    ST_END: begin
                        if (sd_clk_en) begin
                            if ((sd_dat_in == 4'hF) && crc_ok) begin
                                blocks_done <= blocks_done + 16'd1;
                                if ((blocks_done + 16'd1) == cnt_q) begin
                                    state <= ST_WAIT_DMA;
                                end else begin
                                    tmo_cnt <= '0;
                                    state   <= ST_WAIT_START;
                                end
                            end else begin
                                status <= STAT_CRC_ERR;
                                state  <= ST_WAIT_DMA;
                            end
                        end
                    end
                    ST_WAIT_DMA: begin
                        // pending must cover the DMA drain, so it only
                        // drops together with done
                        if (rx.rx_dma_done) begin
                            done          <= 1'b1;
                            rx.rx_pending <= 1'b0;
                            state         <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_rx.sv
// Scoreboard bench for sd_data_rx: drives DAT blocks with model CRCs,
// checks packed words, markers, status and completion handshake.
module tb_sd_data_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd_clk_en;
    logic [3:0]  sd_dat_in;
    logic        start;
    logic        abort;
    logic [11:0] block_len;
    logic [15:0] block_count;
    logic [23:0] timeout;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] blocks_done;

    sd_data_rx_if rx_if ();

    sd_data_rx #(.TIMEOUT_W(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .sd_clk_en   (sd_clk_en),
        .sd_dat_in   (sd_dat_in),
        .start       (start),
        .abort       (abort),
        .block_len   (block_len),
        .block_count (block_count),
        .timeout     (timeout),
        .rx          (rx_if),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    int n_strobe = 0;
    int n_start  = 0;
    int n_first  = 0;
    int n_done   = 0;
    int n_gap    = 0;
    logic [31:0] first_word = 32'h0;
    logic [15:0] mcrc [4];
    int abort_word = -1;
    int reset_crc  = -1;
    bit flip_dat2  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always @(negedge clk) begin
        if (rx_if.rx_data_strobe) begin
            chk("q_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("word", rx_if.rx_data_in, exp_q.pop_front());
            if (n_strobe == 0) first_word = rx_if.rx_data_in;
            n_strobe++;
        end
        if (rx_if.rx_block_starting) n_start++;
        if (rx_if.rx_block_starting && rx_if.rx_block_is_first) n_first++;
        if (done) n_done++;
        if (busy && !rx_if.rx_pending) n_gap++;
    end

    task automatic tick(input logic [3:0] d);
        @(negedge clk);
        sd_clk_en = 1'b1;
        sd_dat_in = d;
        @(negedge clk);
        sd_clk_en = 1'b0;
        sd_dat_in = 4'hF;
    endtask

    task automatic send_nib(input logic [3:0] n);
        for (int l = 0; l < 4; l++) mcrc[l] = crc_step(mcrc[l], n[l]);
        tick(n);
    endtask

    task automatic send_block(input int len, input int seed);
        logic [7:0]  b;
        logic [31:0] w;
        logic [3:0]  n;
        for (int l = 0; l < 4; l++) mcrc[l] = 16'h0;
        tick(4'h0);
        w = 32'h0;
        for (int i = 0; i < len; i++) begin
            b = 8'(seed + i);
            w = w | (32'(b) << (8 * (i % 4)));
            if (i % 4 == 3) begin
                exp_q.push_back(w);
                w = 32'h0;
            end
            send_nib(b[7:4]);
            send_nib(b[3:0]);
            if ((i % 4 == 3) && ((i / 4 + 1) == abort_word)) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_pend", 32'(rx_if.rx_pending), 32'd1);
                chk("abort_stat", 32'(status), 32'd3);
                repeat (16) tick(4'h5);
                return;
            end
        end
        for (int k = 15; k >= 0; k--) begin
            if ((15 - k) == reset_crc) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_pend", 32'(rx_if.rx_pending), 32'd0);
                chk("rst_blk", 32'(blocks_done), 32'd0);
                chk("rst_data", rx_if.rx_data_in, 32'd0);
                return;
            end
            n = {mcrc[3][k], mcrc[2][k], mcrc[1][k], mcrc[0][k]};
            if (flip_dat2 && k == 7) n[2] = ~n[2];
            tick(n);
        end
        tick(4'hF);
    endtask

    task automatic go(input int len, input int cnt, input int tmo);
        @(negedge clk);
        block_len   = 12'(len);
        block_count = 16'(cnt);
        timeout     = 24'(tmo);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("go_pend", 32'(rx_if.rx_pending), 32'd1);
        chk("go_stat", 32'(status), 32'd0);
        chk("go_blk", 32'(blocks_done), 32'd0);
    endtask

    task automatic finish_xfer(input int st, input int blk);
        int d0;
        d0 = n_done;
        repeat (20) @(negedge clk);
        chk("hold_pend", 32'(rx_if.rx_pending), 32'd1);
        chk("hold_nodone", 32'(n_done - d0), 32'd0);
        rx_if.rx_dma_done = 1'b1;
        @(negedge clk);
        rx_if.rx_dma_done = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("done_pend", 32'(rx_if.rx_pending), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("status", 32'(status), 32'(st));
        chk("blocks", 32'(blocks_done), 32'(blk));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin : stim
        logic [15:0] c;
        string s;
        int s_str, s_st, s_fi, s_gap;
        reset = 1'b1;
        sd_clk_en = 1'b0;
        sd_dat_in = 4'hF;
        start = 1'b0;
        abort = 1'b0;
        block_len = 12'd64;
        block_count = 16'd1;
        timeout = 24'd0;
        rx_if.rx_dma_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy0", 32'(busy), 32'd0);
        chk("rst_pend0", 32'(rx_if.rx_pending), 32'd0);
        chk("rst_done0", 32'(done), 32'd0);
        chk("rst_stat0", 32'(status), 32'd0);
        chk("rst_data0", rx_if.rx_data_in, 32'd0);

        c = 16'h0;
        s = "123456789";
        for (int i = 0; i < 9; i++) begin
            for (int j = 7; j >= 0; j--) c = crc_step(c, s[i][j]);
        end
        chk("crc_model", 32'(c), 32'h31C3);

        // single 64-byte block
        s_str = n_strobe; s_st = n_start; s_fi = n_first;
        go(64, 1, 0);
        send_block(64, 0);
        chk("t1_strobes", 32'(n_strobe - s_str), 32'd16);
        chk("t1_first_word", first_word, 32'h03020100);
        chk("t1_starts", 32'(n_start - s_st), 32'd1);
        chk("t1_is_first", 32'(n_first - s_fi), 32'd1);
        finish_xfer(0, 1);

        // three 512-byte blocks with gaps
        s_str = n_strobe; s_st = n_start; s_fi = n_first; s_gap = n_gap;
        go(512, 3, 0);
        for (int b = 0; b < 3; b++) begin
            send_block(512, 7 * b + 1);
            if (b < 2) repeat (5) tick(4'hF);
        end
        chk("t2_strobes", 32'(n_strobe - s_str), 32'd384);
        chk("t2_starts", 32'(n_start - s_st), 32'd3);
        chk("t2_is_first", 32'(n_first - s_fi), 32'd1);
        finish_xfer(0, 3);
        chk("t2_pend_gap", 32'(n_gap - s_gap), 32'd0);

        // CRC error on DAT2 in block 2 of 3
        s_str = n_strobe; s_st = n_start;
        go(512, 3, 0);
        send_block(512, 3);
        repeat (5) tick(4'hF);
        flip_dat2 = 1;
        send_block(512, 9);
        flip_dat2 = 0;
        repeat (6) tick(4'h0);
        chk("t3_strobes", 32'(n_strobe - s_str), 32'd256);
        chk("t3_starts", 32'(n_start - s_st), 32'd2);
        finish_xfer(2, 1);

        // timeout of 100 ticks
        s_str = n_strobe;
        go(64, 1, 100);
        repeat (99) tick(4'hF);
        chk("t4_pre_stat", 32'(status), 32'd0);
        chk("t4_pre_busy", 32'(busy), 32'd1);
        tick(4'hF);
        chk("t4_stat", 32'(status), 32'd1);
        finish_xfer(1, 0);
        chk("t4_strobes", 32'(n_strobe - s_str), 32'd0);

        // timeout disabled: waits indefinitely, then abort
        go(64, 1, 0);
        repeat (300) tick(4'hF);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_stat", 32'(status), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        finish_xfer(3, 0);

        // abort mid-DATA after word 5
        s_str = n_strobe;
        go(64, 1, 0);
        abort_word = 5;
        send_block(64, 40);
        abort_word = -1;
        chk("t6_strobes", 32'(n_strobe - s_str), 32'd5);
        finish_xfer(3, 0);

        // reset during CRC, then a clean transfer
        go(64, 1, 0);
        reset_crc = 5;
        send_block(64, 80);
        reset_crc = -1;
        chk("t7_q_empty", 32'(exp_q.size()), 32'd0);
        go(64, 1, 0);
        send_block(64, 100);
        finish_xfer(0, 1);

        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_data_rx.md
# sd_data_rx

SD card DAT-line receive datapath. Deserialises 4-bit DAT data sampled on SD clock enable ticks and checks per-line CRC16 and end bits over a multi-block read. Packs bytes into 32-bit words and presents them as the rx stream to the SD DMA controller (`rx_data_in`, `rx_data_strobe`, `rx_block_starting`, `rx_block_is_first`, `rx_pending`). Completion is held off until the DMA side reports `rx_dma_done`.

## Interface
Parameters:
- `TIMEOUT_W`, 24: width of the start-bit timeout counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `sd_clk_en`  in  1  one-cycle tick at each SD clock rising edge; DAT is sampled only on a tick.
- `sd_dat_in`  in  4  DAT[3:0] from the pad synchroniser.
- `start`  in  1  pulse; begins a transfer when idle, ignored otherwise.
- `abort`  in  1  pulse; terminates the transfer.
- `block_len`  in  12  bytes per block, multiple of 64, 64..2048; sampled at `start`.
- `block_count`  in  16  blocks in the transfer, 1..65535; sampled at `start`. 0 is treated as 1.
- `timeout`  in  TIMEOUT_W  ticks allowed before each start bit; 0 disables the timeout.
- `rx_pending`  out  1  transfer in progress, including the DMA drain.
- `rx_data_in`  out  32  packed word.
- `rx_data_strobe`  out  1  `rx_data_in` valid for exactly this cycle.
- `rx_block_starting`  out  1  one-cycle pulse at each detected start bit.
- `rx_block_is_first`  out  1  qualifies `rx_block_starting` for block 0.
- `rx_dma_done`  in  1  from the DMA controller: FIFO drained, memory writes complete.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  2  0 OK, 1 timeout, 2 CRC/end-bit error, 3 aborted; valid from `done` until the next `start`.
- `blocks_done`  out  16  blocks received with good CRC.

All outputs reset to 0.

## Operation
- State IDLE:
  - On `start`: latch `block_len`/`block_count`, clear `blocks_done` and `status`, set `rx_pending`, go to WAIT_START.
- State WAIT_START:
  - On a tick with DAT==4'b0000 (start bit): pulse `rx_block_starting`. Assert `rx_block_is_first` too if `blocks_done`==0. Clear nibble/byte counters and CRCs, go to DATA.
  - Otherwise count ticks. When the count reaches `timeout` (nonzero), set status=1 and go to WAIT_DMA.
- State DATA:
  - One nibble per tick; the first nibble of a byte is bits [7:4].
  - Byte k of a word occupies `rx_data_in[8k+7:8k]` (little-endian).
  - After 8 nibbles, update `rx_data_in` and pulse `rx_data_strobe`.
  - After `block_len`*2 nibbles, go to CRC.
- State CRC: 16 ticks, shifting the received CRC bits per line. Then go to END.
- State END: one tick.
  - Pass requires DAT==4'b1111 and all four computed CRCs equal to the received ones. On pass, increment `blocks_done`. If `blocks_done`+1 == `block_count`, go to WAIT_DMA; else go to WAIT_START with the timeout counter cleared.
  - On fail: status=2, go to WAIT_DMA. No further blocks are received.
- State WAIT_DMA: hold `rx_pending`=1 until `rx_dma_done`=1. Then, in the same cycle, pulse `done`, clear `rx_pending`, and go to IDLE.
- `abort` in any non-IDLE state other than WAIT_DMA: status=3, go to WAIT_DMA. `abort` in WAIT_DMA or IDLE is ignored.
- CRC: CRC16-CCITT, x^16+x^12+x^5+1, init 0, computed per line over that line's data bits only. The start bit, CRC bits and end bit are excluded.
- Priority within one cycle: reset > abort > timeout > tick processing.

## Timing
- The word containing nibble 8n is registered in the clk cycle after the capturing tick. `rx_data_strobe` is high in that cycle.
- `rx_block_starting` is high the cycle after the start-bit tick.
- Strobes are never adjacent closer than 8 ticks apart.
- `done` and `rx_pending` falling occur one cycle after `rx_dma_done` is seen high in WAIT_DMA, at the earliest.
- `rx_pending` must stay high through WAIT_DMA. The DMA controller abandons FIFO contents if pending drops.
- Reset mid-transfer: return to IDLE next cycle with all outputs at 0. Counters and CRCs are not preserved.

## Structure
- Package `sd_rx_pkg`: state encodings (IDLE, WAIT_START, DATA, CRC, END, WAIT_DMA), status codes, CRC16 polynomial constant.
- Sub-module `sd_crc16_serial`: 1-bit serial CRC16 with clear and enable. Instantiated 4x, one per DAT line.

## Test plan
- Single block: `block_len`=64, count=1, bytes 0x00..0x3F with correct CRCs -> 16 strobes, first word 0x03020100, one `rx_block_starting` with is_first=1. `rx_dma_done` held low 20 cycles, then high -> `done` one cycle later, status=0, `blocks_done`=1.
- Three blocks of 512B, 5-tick gaps between blocks -> 384 strobes. `rx_block_starting` 3 times, is_first only on the first. `rx_pending` continuous.
- CRC bit flipped on DAT2 in block 2 of 3 -> status=2, `blocks_done`=1, no block-3 `rx_block_starting`, `done` after `rx_dma_done`.
- `timeout`=100 with no start bit -> status=1 at tick 100, zero strobes. With `timeout`=0 and no start bit -> stays in WAIT_START.
- `abort` mid-DATA at word 5 -> no further strobes, status=3, `rx_pending` high until `rx_dma_done`.
- `reset` asserted during CRC state -> next cycle `busy`=0, `rx_pending`=0. A following `start` completes normally.
